// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t    : controller FSM encoding (IDLE, RMW)
//   BE_W       : byte-enable width for a 32-bit data word
//   WORD_MASK  : clears the byte offset of a byte address
//   M0 / M1    : requester indices (load/store unit, debug/DMA port)
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    localparam int BE_W = 4;
    localparam int OFS_W = 2;
    localparam logic [63:0] WORD_MASK = ~64'h3;

    localparam int M0 = 0;
    localparam int M1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with a round-robin pointer and a fixed-priority override.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : arbitration allowed this cycle (controller idle)
//   req      : request vector, index M0/M1
//   gnt      : one-hot (or zero) combinational grant vector
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = 1 means m1 is favoured on the next contended cycle.
    logic ptr;

    always_comb begin
        gnt = '0;
        if (!rst && en) begin
            if (req[M0] && (FIXED_PRIO || !req[M1] || !ptr))
                gnt[M0] = 1'b1;
            else if (req[M1])
                gnt[M1] = 1'b1;
        end
    end

    // Pointer moves only when something is actually granted.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (gnt[M0])
            ptr <= 1'b1;
        else if (gnt[M1])
            ptr <= 1'b0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for a word-write, combinational-read data memory.
// Loads and full-word stores complete in one cycle; partial stores become a
// read (grant cycle) followed by a merged full-word write (RMW cycle).
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   mN_req_i/we_i/addr_i/
//     wdata_i/be_i              : requester N command (held until gnt)
//   mN_gnt_o                    : combinational accept
//   mN_rvalid_o / mN_rdata_o    : registered completion and load data
//   mem_req_o/we_o/waddr_o/
//     wdata_o/raddr_o, mem_rdata_i : memory port
//   busy_o                      : read-modify-write in progress
// DATA_W is expected to equal 8*BE_W.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [BE_W-1:0]   m0_be_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [BE_W-1:0]   m1_be_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    state_t            state, state_nxt;
    logic [1:0]        gnt;
    logic              sel;
    logic              s_we, s_full, s_none, s_partial;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [BE_W-1:0]   s_be;

    logic [DATA_W-1:0] q_old, q_wdata, merged;
    logic [ADDR_W-1:0] q_addr;
    logic [BE_W-1:0]   q_be;
    logic              q_owner;

    logic [1:0]              rvalid_q;
    logic [1:0][DATA_W-1:0]  rdata_q;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == IDLE),
        .req ({m1_req_i, m0_req_i}),
        .gnt (gnt)
    );

    // Command mux follows the grant; when nothing is granted the m0 fields
    // pass through but are never acted on.
    assign sel       = gnt[M1];
    assign s_we      = sel ? m1_we_i    : m0_we_i;
    assign s_addr    = (sel ? m1_addr_i : m0_addr_i) & WORD_MASK[ADDR_W-1:0];
    assign s_wdata   = sel ? m1_wdata_i : m0_wdata_i;
    assign s_be      = sel ? m1_be_i    : m0_be_i;
    assign s_full    = &s_be;
    assign s_none    = ~|s_be;
    assign s_partial = s_we && !s_full && !s_none;

    always_comb begin
        merged = q_old;
        for (int i = 0; i < BE_W; i++)
            if (q_be[i])
                merged[8*i +: 8] = q_wdata[8*i +: 8];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|gnt && s_partial) state_nxt = RMW;
            RMW:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. Reset overrides everything so an aborted RMW never writes.
    always_comb begin
        m0_gnt_o    = gnt[M0];
        m1_gnt_o    = gnt[M1];
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_waddr_o = s_addr;
        mem_wdata_o = s_wdata;
        mem_raddr_o = s_addr;
        busy_o      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        if (!s_we) begin
                            mem_req_o = 1'b1;
                        end else if (s_full) begin
                            mem_req_o = 1'b1;
                            mem_we_o  = 1'b1;
                        end else if (!s_none) begin
                            mem_req_o = 1'b1;   // read half of the RMW
                        end
                    end
                end
                RMW: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_waddr_o = q_addr;
                    mem_wdata_o = merged;
                    mem_raddr_o = q_addr;
                    busy_o      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Completion responses and RMW context.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            q_old    <= '0;
            q_wdata  <= '0;
            q_addr   <= '0;
            q_be     <= '0;
            q_owner  <= 1'b0;
        end else begin
            rvalid_q <= '0;
            if (state == IDLE && |gnt) begin
                if (s_partial) begin
                    q_old   <= mem_rdata_i;
                    q_wdata <= s_wdata;
                    q_addr  <= s_addr;
                    q_be    <= s_be;
                    q_owner <= sel;
                end else begin
                    rvalid_q[sel] <= 1'b1;
                    rdata_q[sel]  <= s_we ? '0 : mem_rdata_i;
                end
            end else if (state == RMW) begin
                rvalid_q[q_owner] <= 1'b1;
                rdata_q[q_owner]  <= '0;
            end
        end
    end

    assign m0_rvalid_o = rvalid_q[M0];
    assign m1_rvalid_o = rvalid_q[M1];
    assign m0_rdata_o  = rdata_q[M0];
    assign m1_rdata_o  = rdata_q[M1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance with a behavioural
// memory, plus a fixed-priority instance sharing the same request inputs.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_mem_req, fp_mem_we, fp_busy;
    logic [31:0] fp_mem_waddr, fp_mem_wdata, fp_mem_raddr;
    logic [31:0] fp_mem_rdata = 32'h0;

    logic [31:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_req && mem_we)
            mem[mem_waddr[7:2]] <= mem_wdata;

    assign mem_rdata = mem[mem_raddr[7:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_waddr_o(mem_waddr),
        .mem_wdata_o(mem_wdata), .mem_raddr_o(mem_raddr),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
        .mem_req_o(fp_mem_req), .mem_we_o(fp_mem_we), .mem_waddr_o(fp_mem_waddr),
        .mem_wdata_o(fp_mem_wdata), .mem_raddr_o(fp_mem_raddr),
        .mem_rdata_i(fp_mem_rdata), .busy_o(fp_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv0(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // ---- reset state, with requests present during reset
        step();
        drv0(1, 0, 32'h10, 0, 0);
        drv1(1, 1, 32'h14, 32'h1, 4'hF);
        mid();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_fp_gnt", {fp_m0_gnt, fp_m1_gnt, fp_mem_req, fp_busy}, 0);
        do_reset();

        // ---- full store 0xDEADBEEF to 0x10, then load it back (addr bits [1:0] ignored)
        drv0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        mid();
        chk("st_gnt", m0_gnt, 1);
        chk("st_mem_req_we", {mem_req, mem_we}, 2'b11);
        chk("st_waddr", mem_waddr, 32'h10);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        drv0(1, 0, 32'h13, 0, 0);
        mid();
        chk("st_rvalid", m0_rvalid, 1);
        chk("st_rdata", m0_rdata, 0);
        chk("ld_gnt", m0_gnt, 1);
        chk("ld_we", mem_we, 0);
        chk("ld_raddr", mem_raddr, 32'h10);
        step();
        drv0(0, 0, 0, 0, 0);
        mid();
        chk("ld_rvalid", m0_rvalid, 1);
        chk("ld_rdata", m0_rdata, 32'hDEADBEEF);
        chk("ld_we_after", mem_we, 0);

        // ---- round robin from reset, both loading continuously
        do_reset();
        drv0(1, 0, 32'h10, 0, 0);
        drv1(1, 0, 32'h10, 0, 0);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("rr_m0_gnt", m0_gnt, (i % 2) == 0);
            chk("rr_m1_gnt", m1_gnt, (i % 2) == 1);
            if (i > 0) begin
                chk("rr_m0_rvalid", m0_rvalid, ((i - 1) % 2) == 0);
                chk("rr_m1_rvalid", m1_rvalid, ((i - 1) % 2) == 1);
            end
            step();
        end
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        mid();
        chk("rr_last_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
        chk("rr_last_rdata", m1_rdata, 32'hDEADBEEF);

        // ---- partial store via m1 with m0 load waiting behind it
        step();
        drv1(1, 1, 32'h30, 32'h11223344, 4'hF);
        step();
        drv1(1, 1, 32'h30, 32'h0000AB00, 4'b0010);
        mid();
        chk("pw_gnt", m1_gnt, 1);
        chk("pw_rd_only", {mem_req, mem_we}, 2'b10);
        chk("pw_raddr", mem_raddr, 32'h30);
        chk("pw_busy0", busy, 0);
        step();
        drv1(0, 0, 0, 0, 0);
        drv0(1, 0, 32'h30, 0, 0);
        mid();
        chk("pw_rmw_busy", busy, 1);
        chk("pw_rmw_gnts", {m0_gnt, m1_gnt}, 0);
        chk("pw_rmw_we", {mem_req, mem_we}, 2'b11);
        chk("pw_rmw_waddr", mem_waddr, 32'h30);
        chk("pw_rmw_wdata", mem_wdata, 32'h1122AB44);
        chk("pw_rmw_rvalid", m1_rvalid, 0);
        step();
        mid();
        chk("pw_m1_rvalid", m1_rvalid, 1);
        chk("pw_m1_rdata", m1_rdata, 0);
        chk("pw_m0_gnt", m0_gnt, 1);
        chk("pw_busy_done", busy, 0);
        step();
        drv0(0, 0, 0, 0, 0);
        mid();
        chk("pw_m0_rvalid", m0_rvalid, 1);
        chk("pw_m0_rdata", m0_rdata, 32'h1122AB44);

        // ---- back-to-back full stores, then a load of the just-written word
        step();
        drv0(1, 1, 32'h20, 32'hA5A5A5A5, 4'hF);
        mid();
        chk("b2b_w0", {m0_gnt, mem_we, busy}, 3'b110);
        chk("b2b_w0_addr", mem_waddr, 32'h20);
        step();
        drv0(1, 1, 32'h24, 32'h5A5A5A5A, 4'hF);
        mid();
        chk("b2b_w1", {m0_gnt, mem_we, busy, m0_rvalid}, 4'b1101);
        chk("b2b_w1_addr", mem_waddr, 32'h24);
        chk("b2b_w1_data", mem_wdata, 32'h5A5A5A5A);
        step();
        drv0(1, 0, 32'h24, 0, 0);
        mid();
        chk("b2b_ld", {m0_gnt, mem_we, busy, m0_rvalid}, 4'b1001);
        step();
        drv0(0, 0, 0, 0, 0);
        mid();
        chk("b2b_ld_rvalid", m0_rvalid, 1);
        chk("b2b_ld_rdata", m0_rdata, 32'h5A5A5A5A);
        chk("b2b_mem20", mem[8], 32'hA5A5A5A5);
        chk("b2b_mem24", mem[9], 32'h5A5A5A5A);

        // ---- be=0 store: granted, no memory access, still completes
        step();
        drv0(1, 1, 32'h20, 32'h12345678, 4'h0);
        mid();
        chk("be0_gnt", m0_gnt, 1);
        chk("be0_mem", {mem_req, mem_we}, 0);
        step();
        drv0(0, 0, 0, 0, 0);
        mid();
        chk("be0_rvalid", {m0_rvalid, busy}, 2'b10);
        chk("be0_mem20", mem[8], 32'hA5A5A5A5);

        // ---- reset during the RMW cycle aborts the write
        step();
        drv0(1, 1, 32'h20, 32'h000000FF, 4'b0001);
        mid();
        chk("ab_gnt", m0_gnt, 1);
        step();
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0);
        mid();
        chk("ab_rst_mem", {mem_req, mem_we}, 0);
        chk("ab_rst_gnt", {m0_gnt, m1_gnt}, 0);
        step();
        rst = 1'b0;
        drv0(1, 0, 32'h20, 0, 0);
        drv1(1, 0, 32'h20, 0, 0);
        mid();
        chk("ab_outs", {m0_rvalid, m1_rvalid, busy}, 0);
        chk("ab_rdata", {m0_rdata, m1_rdata}, 0);
        chk("ab_first_gnt", {m0_gnt, m1_gnt}, 2'b10);
        chk("ab_mem20", mem[8], 32'hA5A5A5A5);

        // ---- fixed priority instance: m1 starves until m0 lets go
        do_reset();
        drv0(1, 0, 32'h10, 0, 0);
        drv1(1, 0, 32'h14, 0, 0);
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("fp_m0_gnt", fp_m0_gnt, 1);
            chk("fp_m1_gnt", fp_m1_gnt, 0);
            step();
        end
        drv0(0, 0, 0, 0, 0);
        mid();
        chk("fp_m1_after", {fp_m0_gnt, fp_m1_gnt}, 2'b01);
        step();
        drv1(0, 0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller in front of the single-port-write, combinational-read data memory: arbitrates the core load/store unit (m0) and the debug/DMA port (m1).
- Converts byte-enabled partial stores into a read-modify-write sequence, because the memory only accepts full 32-bit word writes.
- Registers read data so every completed request receives a one-cycle rvalid response.

Parameters:
- ADDR_W, 32, byte address width of requester and memory ports.
- DATA_W, 32, data width; BE_W = DATA_W/8 (fixed 4 at default).
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 strict priority.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mN_req_i  in  1  request, held with fields stable until mN_gnt_o (N = 0, 1 for all mN_* ports).
- mN_we_i  in  1  1 = store, 0 = load.
- mN_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- mN_wdata_i  in  DATA_W  store data.
- mN_be_i  in  BE_W  byte enables for stores; ignored for loads.
- mN_gnt_o  out  1  combinational accept, one cycle per request.
- mN_rvalid_o  out  1  completion pulse, cycle after accept (full write/read) or two cycles after (partial write).
- mN_rdata_o  out  DATA_W  load data, valid with rvalid; 0 for stores.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_waddr_o  out  ADDR_W  memory write address, word-aligned.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_raddr_o  out  ADDR_W  memory read address, word-aligned.
- mem_rdata_i  in  DATA_W  combinational memory read data.
- busy_o  out  1  high while in RMW state.

Behaviour:
- Reset values: gnt 0, rvalid 0, rdata 0, mem_req/mem_we 0, busy 0, state IDLE, round-robin pointer favours m0.
- FSM states: IDLE, RMW.
- IDLE arbitration:
  - FIXED_PRIO=1: m0 wins whenever requesting.
  - FIXED_PRIO=0: when both request, grant the one not granted last; a lone requester always wins; the pointer updates only on a grant.
- IDLE, load granted at cycle N:
  - mem_raddr_o = {addr[ADDR_W-1:2],2'b00} combinationally.
  - mem_rdata_i registered into mN_rdata_o; rvalid at N+1.
- IDLE, store with be=4'hF:
  - mem_req/mem_we/waddr/wdata driven in cycle N; write occurs at the N edge.
  - rvalid at N+1, rdata 0.
- IDLE, store with be=4'h0: granted, no memory access, rvalid at N+1.
- IDLE, partial store (be neither 0 nor F):
  - Cycle N: grant; read the addressed word; latch old word, addr, wdata, be, owner; go to RMW.
  - RMW cycle N+1: write merged word, byte i = be[i] ? wdata byte i : old byte i.
  - rvalid at N+2; return to IDLE.
- RMW: no grants to either requester; requests wait.
- Back-to-back: in IDLE a new grant is possible every cycle, so reads and full writes pipeline at one per cycle. A load following a store to the same word in the next cycle sees the updated data.
- Reset mid-RMW: abort, no memory write, state IDLE, all outputs to reset values.
- rst is checked before everything else: during rst, all gnt and mem_req are forced to 0.
- Only one of m0_gnt_o / m1_gnt_o is high in any cycle; mem_we_o is never high without mem_req_o.

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE, RMW), BE_W, word-align mask, requester index constants M0/M1.
- One sub-module: rr_arb2, a 2-way round-robin arbiter with FIXED_PRIO override and pointer register.
- Merge logic and FSM stay in dmem_arbiter.

Test Plan:
- m0 load addr 0x10, mem word 0xDEADBEEF -> m0_gnt at N, m0_rvalid at N+1 with m0_rdata=0xDEADBEEF, mem_we_o 0 throughout.
- Both loads requested continuously from reset, FIXED_PRIO=0 -> grant order m0, m1, m0, m1; rvalid follows each grant by 1 cycle.
- m1 store be=4'b0010 wdata 0x0000AB00 to word 0x11223344; m0 load requested at N+1:
  - Memory write 0x1122AB44 at N+1, m1_rvalid at N+2, busy_o high at N+1.
  - m0 granted only at N+2 and reads 0x1122AB44.
- m0 full stores 0xA5A5A5A5 to 0x20 then 0x5A5A5A5A to 0x24 back-to-back -> writes at N and N+1, rvalid at N+1 and N+2, no RMW state entered.
- rst asserted in the RMW cycle of a partial store -> no memory write, word unchanged, all outputs 0 the next cycle, next grant goes to m0.
- FIXED_PRIO=1, both requesting continuously for 8 cycles -> m1_gnt never asserted; m1 granted the first cycle m0_req drops.
